// File: rtl/adc_capture_pkg.sv
// Shared definitions for the triggered ADC capture buffer.
package adc_capture_pkg;

    localparam int DEPTH_LOG2_DEF = 10;
    localparam int DATA_W_DEF     = 8;
    localparam int PAIR_W_DEF     = 2 * DATA_W_DEF;

    // Encoding is visible on the state output, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRETRIG  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTTRIG = 3'd3,
        ST_DONE     = 3'd4
    } cap_state_e;

endpackage

// File: rtl/adc_capture_buffer_if.sv
// Control, sample and readback signals of the capture buffer.
// master: the side driving samples/commands (LVDS stage + bridge).
// slave:  the capture buffer itself.
interface adc_capture_buffer_if
    import adc_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DATA_W     = DATA_W_DEF
);
    logic [DATA_W-1:0]     cha_data;
    logic [DATA_W-1:0]     chb_data;
    logic                  arm;
    logic                  force_trig;
    logic                  trig_src;
    logic                  trig_slope;
    logic [DATA_W-1:0]     trig_level;
    logic [DEPTH_LOG2-1:0] pretrig;
    logic                  rd_start;
    logic                  rd_en;
    logic [2*DATA_W-1:0]   rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic [2:0]            state;
    logic                  done;
    logic [DEPTH_LOG2-1:0] trig_addr;

    modport master (
        output cha_data, chb_data, arm, force_trig, trig_src, trig_slope,
               trig_level, pretrig, rd_start, rd_en,
        input  rd_data, rd_valid, rd_last, state, done, trig_addr
    );

    modport slave (
        input  cha_data, chb_data, arm, force_trig, trig_src, trig_slope,
               trig_level, pretrig, rd_start, rd_en,
        output rd_data, rd_valid, rd_last, state, done, trig_addr
    );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port record RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module capture_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read port, one cycle latency.
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered capture of AD9284 A/B sample pairs into a circular record,
// with a sequential readback port usable once the record is complete.
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                 adc_dco_clk,
    input  logic                 reset,
    adc_capture_buffer_if.slave  bus
);
    localparam int                    PAIR_W  = 2 * DATA_W;
    localparam int                    DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   RD_LAST = (DEPTH_LOG2+1)'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0]   RD_ONE  = (DEPTH_LOG2+1)'(1);

    cap_state_e            state_q, state_d;
    logic                  src_q, src_d;
    logic                  slope_q, slope_d;
    logic [DATA_W-1:0]     level_q, level_d;
    logic [DATA_W-1:0]     prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [DEPTH_LOG2-1:0] pretrig_q, pretrig_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] trig_addr_q, trig_addr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
    logic                  done_q, done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;

    logic                  wr_en;
    logic                  rd_accept;
    logic                  trig_hit;
    logic [DATA_W-1:0]     cur;
    logic [DEPTH_LOG2-1:0] start_addr;
    logic [PAIR_W-1:0]     ram_rdata;

    // Level-crossing comparator on the latched channel, same-cycle input.
    // prev_valid keeps a stale previous sample from firing right after arm.
    always_comb begin
        logic rise, fall;
        cur      = src_q ? bus.chb_data : bus.cha_data;
        rise     = prev_valid_q && (prev_q <  level_q) && (cur >= level_q);
        fall     = prev_valid_q && (prev_q >= level_q) && (cur <  level_q);
        trig_hit = bus.force_trig || (slope_q ? fall : rise);
    end

    // Capture FSM: arm takes priority over everything (including force).
    // The pretrig port width already bounds the request to 2^DEPTH_LOG2-1.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        slope_d      = slope_q;
        level_d      = level_q;
        pretrig_d    = pretrig_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        trig_addr_d  = trig_addr_q;
        done_d       = done_q;
        wr_en        = 1'b0;
        if (bus.arm) begin
            src_d        = bus.trig_src;
            slope_d      = bus.trig_slope;
            level_d      = bus.trig_level;
            pretrig_d    = bus.pretrig;
            cnt_d        = bus.pretrig;
            wr_ptr_d     = '0;
            prev_valid_d = 1'b0;
            done_d       = 1'b0;
            state_d      = ST_PRETRIG;
        end else begin
            case (state_q)
                ST_PRETRIG: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        cnt_d    = cnt_q - PTR_ONE;
                        if (cnt_q == PTR_ONE) state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + PTR_ONE;
                    prev_d       = cur;
                    prev_valid_d = 1'b1;
                    if (trig_hit) begin
                        trig_addr_d = wr_ptr_q;
                        cnt_d       = PTR_MAX - pretrig_q;
                        if (pretrig_q == PTR_MAX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_POSTTRIG;
                        end
                    end
                end
                ST_POSTTRIG: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    cnt_d    = cnt_q - PTR_ONE;
                    if (cnt_q <= PTR_ONE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign start_addr = trig_addr_q - pretrig_q;

    // Readback sequencer: reads only in DONE, one pass of DEPTH pairs per rd_start.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        rd_cnt_d  = rd_cnt_q;
        rd_accept = (state_q == ST_DONE) && bus.rd_en && !bus.rd_start &&
                    !bus.arm && !rd_cnt_q[DEPTH_LOG2];
        if ((state_q == ST_DONE) && bus.rd_start && !bus.arm) begin
            rd_ptr_d = start_addr;
            rd_cnt_d = '0;
        end else if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rd_cnt_d = rd_cnt_q + RD_ONE;
        end
        rd_valid_d = rd_accept;
        rd_last_d  = rd_accept && (rd_cnt_q == RD_LAST);
    end

    // State, pointer and flag registers.
    always_ff @(posedge adc_dco_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            src_q        <= 1'b0;
            slope_q      <= 1'b0;
            level_q      <= '0;
            pretrig_q    <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            slope_q      <= slope_d;
            level_q      <= level_d;
            pretrig_q    <= pretrig_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            trig_addr_q  <= trig_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            done_q       <= done_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
        end
    end

    capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (PAIR_W)
    ) u_ram (
        .clk_i   (adc_dco_clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.chb_data, bus.cha_data}),
        .re_i    (rd_accept),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // The RAM read register has no reset; gating keeps rd_data at 0
    // out of reset and between reads.
    assign bus.rd_data   = rd_valid_q ? ram_rdata : '0;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.state     = state_q;
    assign bus.done      = done_q;
    assign bus.trig_addr = trig_addr_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer at DEPTH_LOG2=4, DATA_W=8.
module tb_adc_capture_buffer;
    import adc_capture_pkg::*;

    localparam int DL = 4;
    localparam int DW = 8;
    localparam int N  = 1 << DL;

    logic clk = 1'b0;
    logic rst;

    adc_capture_buffer_if #(.DEPTH_LOG2(DL), .DATA_W(DW)) bus();

    adc_capture_buffer #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
        .adc_dco_clk (clk),
        .reset       (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Capture scenario: stimulus kind, settings, hand-computed results.
    // Cycle c counts edges after the arm edge (arm edge is c=0).
    typedef struct {
        int         kind;      // 0: cha=c, chb=~c   1: cha=c, chb=0x90 then 0x70 from c=20
        logic       src;
        logic       slope;
        logic [7:0] level;
        logic [3:0] pre;
        int         force_c;   // -1: never
        int         trig_c;
        logic [2:0] trig_state;
        logic [3:0] taddr;
        int         first_c;   // cycle whose sample is the first record pair
        int         done_c;
    } row_t;

    row_t rows[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int kind, input int c);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(c);
        if (kind == 0) b = ~a;
        else           b = (c < 20) ? 8'h90 : 8'h70;
        return {b, a};
    endfunction

    task automatic drive(input int kind, input int c);
        logic [15:0] p;
        p = pat(kind, c);
        bus.cha_data = p[7:0];
        bus.chb_data = p[15:8];
    endtask

    task automatic set_cfg(input logic src, input logic slope, input logic [7:0] lvl, input logic [3:0] pre);
        bus.trig_src   = src;
        bus.trig_slope = slope;
        bus.trig_level = lvl;
        bus.pretrig    = pre;
    endtask

    task automatic run_row(input int r);
        row_t v;
        v = rows[r];
        set_cfg(v.src, v.slope, v.level, v.pre);
        bus.arm = 1'b1;
        drive(v.kind, 0);
        tick();
        bus.arm = 1'b0;
        chk($sformatf("r%0d arm state", r), 32'(bus.state), 32'(ST_PRETRIG));
        for (int c = 1; c <= v.done_c; c++) begin
            drive(v.kind, c);
            bus.force_trig = (c == v.force_c);
            tick();
            if (c == v.trig_c) begin
                chk($sformatf("r%0d trig state", r), 32'(bus.state), 32'(v.trig_state));
                chk($sformatf("r%0d trig_addr", r), 32'(bus.trig_addr), 32'(v.taddr));
            end
            if (c == v.done_c - 1)
                chk($sformatf("r%0d done early", r), 32'(bus.done), 32'd0);
            if (c == v.done_c) begin
                chk($sformatf("r%0d done", r), 32'(bus.done), 32'd1);
                chk($sformatf("r%0d done state", r), 32'(bus.state), 32'(ST_DONE));
            end
        end
        bus.force_trig = 1'b0;
        // Two passes: the second rd_start must replay the same record.
        for (int pass = 0; pass < 2; pass++) begin
            bus.rd_start = 1'b1;
            tick();
            bus.rd_start = 1'b0;
            for (int i = 0; i <= N; i++) begin
                bus.rd_en = 1'b1;
                tick();
                if (i < N) begin
                    chk($sformatf("r%0d p%0d valid[%0d]", r, pass, i), 32'(bus.rd_valid), 32'd1);
                    chk($sformatf("r%0d p%0d data[%0d]", r, pass, i), 32'(bus.rd_data),
                        32'(pat(v.kind, v.first_c + i)));
                    chk($sformatf("r%0d p%0d last[%0d]", r, pass, i), 32'(bus.rd_last), 32'(i == N - 1));
                end else begin
                    chk($sformatf("r%0d p%0d extra read", r, pass), 32'(bus.rd_valid), 32'd0);
                end
            end
            bus.rd_en = 1'b0;
        end
    endtask

    initial begin
        //          kind src slope level  pre force trig state        taddr first done
        rows[0] = '{0, 1'b0, 1'b0, 8'd100,  4'd4,  -1, 100, ST_POSTTRIG, 4'd3,  96, 111};
        rows[1] = '{1, 1'b1, 1'b1, 8'h80,   4'd4,  -1,  20, ST_POSTTRIG, 4'd3,  16,  31};
        rows[2] = '{0, 1'b0, 1'b0, 8'd100,  4'd0,  -1, 100, ST_POSTTRIG, 4'd2, 100, 115};
        rows[3] = '{0, 1'b0, 1'b0, 8'd100,  4'd15, -1, 100, ST_DONE,     4'd3,  85, 100};
        rows[4] = '{0, 1'b0, 1'b0, 8'd0,    4'd4,  50,  50, ST_POSTTRIG, 4'd1,  46,  61};

        rst            = 1'b1;
        bus.cha_data   = '0;
        bus.chb_data   = '0;
        bus.arm        = 1'b0;
        bus.force_trig = 1'b0;
        bus.rd_start   = 1'b0;
        bus.rd_en      = 1'b0;
        set_cfg(1'b0, 1'b0, 8'd0, 4'd0);
        tick();
        tick();
        chk("reset state", 32'(bus.state), 32'(ST_IDLE));
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset trig_addr", 32'(bus.trig_addr), 32'd0);
        chk("reset rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset rd_last", 32'(bus.rd_last), 32'd0);
        chk("reset rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // rd_en while IDLE is ignored.
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("idle rd_en valid", 32'(bus.rd_valid), 32'd0);

        for (int r = 0; r < 5; r++) run_row(r);

        // rd_start with rd_en on the same cycle: rd_en dropped, pointer not advanced.
        bus.rd_start = 1'b1;
        bus.rd_en    = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        chk("rd_start+rd_en valid", 32'(bus.rd_valid), 32'd0);
        tick();
        chk("post rd_start valid", 32'(bus.rd_valid), 32'd1);
        chk("post rd_start data", 32'(bus.rd_data), 32'(pat(0, 46)));

        // arm during readout: valid drops on the next cycle, capture restarts.
        set_cfg(1'b0, 1'b0, 8'd0, 4'd4);
        bus.arm = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.rd_en = 1'b0;
        chk("arm in readout valid", 32'(bus.rd_valid), 32'd0);
        chk("arm in readout state", 32'(bus.state), 32'(ST_PRETRIG));

        // arm and force together: arm wins, no trigger.
        set_cfg(1'b0, 1'b0, 8'd150, 4'd0);
        bus.cha_data   = 8'd10;
        bus.arm        = 1'b1;
        bus.force_trig = 1'b1;
        tick();
        bus.arm        = 1'b0;
        bus.force_trig = 1'b0;
        chk("arm+force state", 32'(bus.state), 32'(ST_PRETRIG));
        tick();
        chk("pretrig0 armed", 32'(bus.state), 32'(ST_ARMED));
        tick();
        tick();
        chk("flat no trig", 32'(bus.state), 32'(ST_ARMED));

        // Re-arm: stale prev (10) must not combine with the first ARMED sample.
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        tick();
        chk("rearm armed", 32'(bus.state), 32'(ST_ARMED));
        bus.cha_data = 8'd200;
        bus.rd_en    = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("first sample no trig", 32'(bus.state), 32'(ST_ARMED));
        chk("armed rd_en valid", 32'(bus.rd_valid), 32'd0);
        tick();
        chk("equal samples no trig", 32'(bus.state), 32'(ST_ARMED));
        bus.cha_data = 8'd100;
        tick();
        bus.cha_data = 8'd200;
        tick();
        chk("rising trig state", 32'(bus.state), 32'(ST_POSTTRIG));
        chk("rising trig_addr", 32'(bus.trig_addr), 32'd3);

        // Asynchronous reset in POSTTRIG, well away from a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async rst state", 32'(bus.state), 32'(ST_IDLE));
        chk("async rst done", 32'(bus.done), 32'd0);
        chk("async rst trig_addr", 32'(bus.trig_addr), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        run_row(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
